// File: rtl/dcache_arb_pkg.sv
// Shared types and width helpers for the data-cache port arbiter.
//   rw_flag_e   : mem_dcache request encoding (0 none, 1 read, 2 write)
//   arb_state_e : arbiter FSM states
//   arb_idx_w   : index width for a requester count
//   arb_wd_w    : watchdog counter width for a timeout length
package dcache_arb_pkg;

  typedef enum logic [2:0] {
    DC_NONE  = 3'd0,
    DC_READ  = 3'd1,
    DC_WRITE = 3'd2
  } rw_flag_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Counter must reach t-1; a disabled watchdog (t == 0) still gets one bit.
  function automatic int unsigned arb_wd_w(input int unsigned t);
    return (t > 32'd1) ? 32'($clog2(t)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_ptr   : index of the last winner; the scan starts just after it
//   o_grant : one-hot winner (all zero when no request)
//   o_idx   : winner index
module rr_priority_pick
  import dcache_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]              i_req,
  input  logic [arb_idx_w(N)-1:0]   i_ptr,
  output logic [N-1:0]              o_grant,
  output logic [arb_idx_w(N)-1:0]   o_idx
);

  localparam int unsigned IDX_W = arb_idx_w(N);

  logic w_found;

  // Two passes: indices above the pointer first, then the wrap-around part.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (IDX_W'(i) > i_ptr)) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (IDX_W'(i) <= i_ptr)) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port among NUM_REQ requesters with round-robin
// grant, one transaction in flight and registered downstream drive.
//   clk, rst                  : clock, async active-high reset
//   flush                     : pipeline flush, cancels speculative reads
//   req_rw_flag/addr/wdata/wmask : per-requester request, held until req_done
//   req_grant, req_done, req_rdata : per-requester grant, done pulse, read data
//   dc_rw_flag/addr/write_data/write_mask : registered drive to the dcache
//   dc_read_data, dc_busy, dc_done : dcache response
//   timeout_err               : sticky watchdog error
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned        NUM_REQ     = 2,
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter logic [NUM_REQ-1:0] FLUSHABLE   = NUM_REQ'(2'b01),
  parameter int unsigned        TIMEOUT_CYC = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0][2:0]             req_rw_flag,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_wdata,
  input  logic [NUM_REQ-1:0][(DATA_W/8)-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [NUM_REQ-1:0][DATA_W-1:0]      req_rdata,
  output logic [2:0]                          dc_rw_flag,
  output logic [ADDR_W-1:0]                   dc_addr,
  output logic [DATA_W-1:0]                   dc_write_data,
  output logic [(DATA_W/8)-1:0]               dc_write_mask,
  input  logic [DATA_W-1:0]                   dc_read_data,
  input  logic                                dc_busy,
  input  logic                                dc_done,
  output logic                                timeout_err
);

  localparam int unsigned MASK_W   = DATA_W / 8;
  localparam int unsigned IDX_W    = arb_idx_w(NUM_REQ);
  localparam int unsigned ARB_WD_W = arb_wd_w(TIMEOUT_CYC);

  arb_state_e                    r_state;
  arb_state_e                    w_state_nxt;
  logic [IDX_W-1:0]              r_rr_ptr;
  logic [IDX_W-1:0]              r_gnt_idx;
  logic [NUM_REQ-1:0]            r_grant;
  logic [NUM_REQ-1:0]            r_done;
  logic [NUM_REQ-1:0][DATA_W-1:0] r_rdata;
  logic [2:0]                    r_dc_flag;
  logic [ADDR_W-1:0]             r_dc_addr;
  logic [DATA_W-1:0]             r_dc_wdata;
  logic [MASK_W-1:0]             r_dc_wmask;
  logic                          r_kill;
  logic [ARB_WD_W-1:0]           r_wd;
  logic                          r_timeout_err;

  logic [NUM_REQ-1:0]            w_elig;
  logic [NUM_REQ-1:0]            w_pick_oh;
  logic [IDX_W-1:0]              w_pick_idx;
  logic                          w_flush_hit;
  logic                          w_wd_hit;
  logic                          w_launch;
  logic                          w_finish;
  logic                          w_done_ok;
  logic                          w_wd_fire;
  logic                          w_busy_hold;

  // Flag values other than read/write count as no request; flush masks speculative requesters.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = ((req_rw_flag[i] == DC_READ) || (req_rw_flag[i] == DC_WRITE)) &&
                  !(flush && FLUSHABLE[i]);
    end
  end

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx)
  );

  // Only reads of flushable requesters are cancelled; writes always complete.
  assign w_flush_hit = flush && FLUSHABLE[r_gnt_idx] && (r_dc_flag == DC_READ);
  assign w_wd_hit    = (TIMEOUT_CYC != 0) && (r_wd == ARB_WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus one-cycle control strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    w_done_ok   = 1'b0;
    w_wd_fire   = 1'b0;
    w_busy_hold = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if ((|w_elig) && !dc_busy) begin
          w_launch    = 1'b1;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (dc_done) begin
          // A flush landing together with dc_done still suppresses the pulse.
          w_finish    = 1'b1;
          w_done_ok   = !(r_kill || w_flush_hit);
          w_state_nxt = ARB_DRAIN;
        end else if (w_wd_hit) begin
          w_finish    = 1'b1;
          w_wd_fire   = 1'b1;
          w_state_nxt = ARB_DRAIN;
        end else begin
          w_busy_hold = 1'b1;
        end
      end
      ARB_DRAIN: w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Registered datapath: launch latches the winner, finish clears the drive and pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx     <= '0;
      r_grant       <= '0;
      r_done        <= '0;
      r_rdata       <= '0;
      r_dc_flag     <= DC_NONE;
      r_dc_addr     <= '0;
      r_dc_wdata    <= '0;
      r_dc_wmask    <= '0;
      r_kill        <= 1'b0;
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done  <= '0;
      r_rdata <= '0;
      if (w_launch) begin
        r_rr_ptr   <= w_pick_idx;
        r_gnt_idx  <= w_pick_idx;
        r_grant    <= w_pick_oh;
        r_dc_flag  <= req_rw_flag[w_pick_idx];
        r_dc_addr  <= req_addr[w_pick_idx];
        r_dc_wdata <= req_wdata[w_pick_idx];
        r_dc_wmask <= req_wmask[w_pick_idx];
        r_kill     <= 1'b0;
        r_wd       <= '0;
      end
      if (w_busy_hold) begin
        r_wd <= r_wd + ARB_WD_W'(1);
        if (w_flush_hit) begin
          r_kill <= 1'b1;
        end
      end
      if (w_finish) begin
        r_grant    <= '0;
        r_dc_flag  <= DC_NONE;
        r_dc_addr  <= '0;
        r_dc_wdata <= '0;
        r_dc_wmask <= '0;
        r_kill     <= 1'b0;
        r_wd       <= '0;
        if (w_done_ok) begin
          r_done[r_gnt_idx]  <= 1'b1;
          r_rdata[r_gnt_idx] <= (r_dc_flag == DC_WRITE) ? '0 : dc_read_data;
        end
      end
      if (w_wd_fire) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign req_grant     = r_grant;
  assign req_done      = r_done;
  assign req_rdata     = r_rdata;
  assign dc_rw_flag    = r_dc_flag;
  assign dc_addr       = r_dc_addr;
  assign dc_write_data = r_dc_wdata;
  assign dc_write_mask = r_dc_wmask;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a transaction-level reference model
// checked every cycle, a small dcache responder, and literal spot checks.
module tb_dcache_port_arbiter;

  localparam int         NR    = 2;
  localparam int         TMO   = 8;
  localparam logic [1:0] FMASK = 2'b01;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [1:0][2:0]   req_rw_flag;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0][3:0]   req_wmask;
  logic [1:0]        req_grant;
  logic [1:0]        req_done;
  logic [1:0][31:0]  req_rdata;
  logic [2:0]        dc_rw_flag;
  logic [31:0]       dc_addr;
  logic [31:0]       dc_write_data;
  logic [3:0]        dc_write_mask;
  logic [31:0]       dc_read_data;
  logic              dc_busy;
  logic              dc_done;
  logic              timeout_err;

  int n_cmp;
  int n_bad;

  dcache_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .FLUSHABLE(FMASK), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_rw_flag(req_rw_flag), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_grant(req_grant), .req_done(req_done),
    .req_rdata(req_rdata), .dc_rw_flag(dc_rw_flag), .dc_addr(dc_addr),
    .dc_write_data(dc_write_data), .dc_write_mask(dc_write_mask),
    .dc_read_data(dc_read_data), .dc_busy(dc_busy), .dc_done(dc_done),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // dcache responder: pulses dc_done rsp_lat cycles after the request first appears.
  int          rsp_lat;
  logic        rsp_en;
  logic [31:0] rsp_data;
  int          rsp_cnt;
  logic        rsp_sent;

  initial begin
    dc_done = 1'b0; dc_read_data = '0; rsp_cnt = 0; rsp_sent = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      dc_done = 1'b0;
      if (dc_rw_flag == 3'd0) begin
        rsp_cnt = 0; rsp_sent = 1'b0;
      end else if (rsp_en && !rsp_sent) begin
        if (rsp_cnt == rsp_lat) begin
          dc_done = 1'b1; dc_read_data = rsp_data; rsp_sent = 1'b1;
        end
        rsp_cnt++;
      end
    end
  end

  // Reference model: one transaction at a time, expected outputs for the next cycle.
  logic             m_inflight, m_drain, m_killed;
  logic [0:0]       m_owner, m_last;
  int               m_busy;
  logic [2:0]       e_flag;
  logic [31:0]      e_addr, e_wdata;
  logic [3:0]       e_wmask;
  logic [1:0]       e_grant, e_done;
  logic [1:0][31:0] e_rdata;
  logic             e_err;

  task automatic model_reset();
    m_inflight = 1'b0; m_drain = 1'b0; m_killed = 1'b0;
    m_owner = 1'b0; m_last = 1'(NR - 1); m_busy = 0;
    e_flag = '0; e_addr = '0; e_wdata = '0; e_wmask = '0;
    e_grant = '0; e_done = '0; e_rdata = '0; e_err = 1'b0;
  endtask

  task automatic model_end();
    m_inflight = 1'b0; m_drain = 1'b1;
    e_flag = '0; e_grant = '0;
  endtask

  task automatic model_step();
    logic       found, fl, was_write;
    logic [0:0] w, ii;
    e_done = '0; e_rdata = '0;
    if (m_drain) begin
      m_drain = 1'b0;
    end else if (!m_inflight) begin
      found = 1'b0; w = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        ii = 1'((int'(m_last) + k) % NR);
        if (!found && (req_rw_flag[ii] == 3'd1 || req_rw_flag[ii] == 3'd2) &&
            !(flush && FMASK[ii])) begin
          found = 1'b1; w = ii;
        end
      end
      if (found && !dc_busy) begin
        m_inflight = 1'b1; m_owner = w; m_last = w; m_killed = 1'b0; m_busy = 0;
        e_flag = req_rw_flag[w]; e_addr = req_addr[w];
        e_wdata = req_wdata[w]; e_wmask = req_wmask[w];
        e_grant = 2'(32'd1 << w);
      end
    end else begin
      m_busy++;
      fl = m_killed || (flush && FMASK[m_owner] && e_flag == 3'd1);
      was_write = (e_flag == 3'd2);
      if (dc_done) begin
        model_end();
        if (!fl) begin
          e_done[m_owner]  = 1'b1;
          e_rdata[m_owner] = was_write ? 32'd0 : dc_read_data;
        end
      end else if (m_busy == TMO) begin
        model_end();
        e_err = 1'b1;
      end else begin
        m_killed = fl;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("grant", 64'(req_grant), 64'(e_grant));
      chk("dc_rw_flag", 64'(dc_rw_flag), 64'(e_flag));
      chk("req_done", 64'(req_done), 64'(e_done));
      chk("req_rdata", 64'(req_rdata), 64'(e_rdata));
      chk("timeout_err", 64'(timeout_err), 64'(e_err));
      if (e_flag != 3'd0) begin
        chk("dc_addr", 64'(dc_addr), 64'(e_addr));
        chk("dc_wdata", 64'(dc_write_data), 64'(e_wdata));
        chk("dc_wmask", 64'(dc_write_mask), 64'(e_wmask));
      end
      if (!rst) model_step();
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish (t=%0t)", $time);
    $fatal(1, "bench stalled");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] want, input int max, input string nm);
    int c = 0;
    while (req_grant != want && c < max) begin tick(1); c++; end
    chk(nm, 64'(req_grant), 64'(want));
  endtask

  task automatic wait_done(input logic [1:0] want, input int max, input string nm);
    int c = 0;
    while (req_done != want && c < max) begin tick(1); c++; end
    chk(nm, 64'(req_done), 64'(want));
  endtask

  int         got[$];
  logic [1:0] prev_g;
  int         overlap, b2b, d0, c;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; flush = 1'b0; dc_busy = 1'b0;
    req_rw_flag = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_en = 1'b1; rsp_lat = 3; rsp_data = '0;
    tick(2);
    chk("reset_grant", 64'(req_grant), 64'd0);
    chk("reset_flag", 64'(dc_rw_flag), 64'd0);
    rst = 1'b0;

    // 1: flag 3 ignored, then single read with done 3 cycles after the flag
    req_rw_flag[0] = 3'd3; req_addr[0] = 32'h100;
    tick(3);
    chk("t1_flag3_nogrant", 64'(req_grant), 64'd0);
    req_rw_flag[0] = 3'd1; rsp_lat = 3; rsp_data = 32'hDEADBEEF;
    tick(1);
    chk("t1_flag_t1", 64'(dc_rw_flag), 64'd1);
    chk("t1_addr", 64'(dc_addr), 64'h100);
    chk("t1_grant", 64'(req_grant), 64'b01);
    tick(3);
    chk("t1_no_done_yet", 64'(req_done), 64'd0);
    tick(1);
    chk("t1_done", 64'(req_done), 64'b01);
    chk("t1_rdata", 64'(req_rdata[0]), 64'hDEADBEEF);
    chk("t1_drain_flag", 64'(dc_rw_flag), 64'd0);
    req_rw_flag[0] = 3'd0;
    tick(2);

    // 2: contention from reset, grants must alternate 0,1,0,1 with a gap
    rst = 1'b1;
    req_rw_flag[0] = 3'd1; req_addr[0] = 32'h200;
    req_rw_flag[1] = 3'd2; req_addr[1] = 32'h300; req_wdata[1] = 32'hA5A5_0001; req_wmask[1] = 4'hF;
    rsp_lat = 1; rsp_data = 32'h0BAD_F00D;
    tick(2);
    rst = 1'b0;
    prev_g = '0; overlap = 0; b2b = 0; c = 0;
    while (got.size() < 4 && c < 80) begin
      if (req_grant != 2'b00 && prev_g == 2'b00) got.push_back(req_grant[1] ? 1 : 0);
      if (req_grant == 2'b11) overlap++;
      if (prev_g != 2'b00 && req_grant != 2'b00 && prev_g != req_grant) b2b++;
      prev_g = req_grant;
      tick(1); c++;
    end
    chk("t2_grant_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 64'((got.size() > k) ? got[k] : -1), 64'(k % 2));
    end
    chk("t2_overlap", 64'(overlap), 64'd0);
    chk("t2_back_to_back", 64'(b2b), 64'd0);
    req_rw_flag = '0;
    wait_grant(2'b00, 20, "t2_settle");
    tick(2);

    // 3: dc_busy and flush block launch; flush kills an in-flight read
    dc_busy = 1'b1; req_rw_flag[0] = 3'd1; req_addr[0] = 32'h400;
    tick(2);
    chk("t3_busy_blocks", 64'(req_grant), 64'd0);
    dc_busy = 1'b0; flush = 1'b1;
    tick(1);
    chk("t3_flush_blocks", 64'(req_grant), 64'd0);
    flush = 1'b0; rsp_lat = 5; rsp_data = 32'h4444_4444;
    wait_grant(2'b01, 5, "t3_grant0");
    req_rw_flag[1] = 3'd2; req_addr[1] = 32'h600; req_wdata[1] = 32'h0000_600D; req_wmask[1] = 4'hF;
    tick(1);
    flush = 1'b1; req_rw_flag[0] = 3'd0;
    tick(1);
    flush = 1'b0; d0 = 0; c = 0;
    while (req_grant != 2'b10 && c < 30) begin
      if (req_done[0]) d0++;
      tick(1); c++;
    end
    chk("t3_next_grant1", 64'(req_grant), 64'b10);
    chk("t3_no_done0", 64'(d0), 64'd0);
    wait_done(2'b10, 20, "t3_done1");
    req_rw_flag[1] = 3'd0;
    tick(2);

    // 3b: flush in the same cycle as dc_done suppresses the pulse
    req_rw_flag[0] = 3'd1; req_addr[0] = 32'h440; rsp_lat = 3; rsp_data = 32'h5555_0000;
    wait_grant(2'b01, 5, "t3b_grant0");
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t3b_no_done", 64'(req_done), 64'd0);
    chk("t3b_drain_grant", 64'(req_grant), 64'd0);
    req_rw_flag[0] = 3'd0;
    tick(2);

    // 4: write is immune to flush and held stable on the port
    req_rw_flag[1] = 3'd2; req_addr[1] = 32'h500; req_wdata[1] = 32'h1234_5678; req_wmask[1] = 4'b0011;
    rsp_lat = 4; rsp_data = 32'hFFFF_FFFF;
    wait_grant(2'b10, 5, "t4_grant1");
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t4_wdata_held", 64'(dc_write_data), 64'h1234_5678);
    chk("t4_wmask_held", 64'(dc_write_mask), 64'b0011);
    chk("t4_flag_held", 64'(dc_rw_flag), 64'd2);
    wait_done(2'b10, 10, "t4_done1");
    chk("t4_rdata_zero", 64'(req_rdata[1]), 64'd0);
    req_rw_flag[1] = 3'd0;
    tick(2);

    // 5: dcache never answers, watchdog fires after 8 BUSY cycles
    rsp_en = 1'b0;
    req_rw_flag[0] = 3'd1; req_addr[0] = 32'h700;
    wait_grant(2'b01, 5, "t5_grant0");
    tick(7);
    chk("t5_err_not_yet", 64'(timeout_err), 64'd0);
    chk("t5_still_busy", 64'(req_grant), 64'b01);
    tick(1);
    chk("t5_err_set", 64'(timeout_err), 64'd1);
    chk("t5_no_done", 64'(req_done), 64'd0);
    chk("t5_released", 64'(req_grant), 64'd0);
    req_rw_flag[0] = 3'd0;
    tick(4);
    chk("t5_err_sticky", 64'(timeout_err), 64'd1);
    chk("t5_idle_flag", 64'(dc_rw_flag), 64'd0);
    rsp_en = 1'b1;

    // 6: async reset mid-BUSY clears outputs at once; requester 0 wins afterwards
    req_rw_flag[1] = 3'd2; req_addr[1] = 32'h800; req_wdata[1] = 32'h88; req_wmask[1] = 4'hF;
    rsp_lat = 6; rsp_data = 32'h9999_0000;
    wait_grant(2'b10, 5, "t6_grant1");
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 64'(req_grant), 64'd0);
    chk("t6_rst_flag", 64'(dc_rw_flag), 64'd0);
    chk("t6_rst_addr", 64'(dc_addr), 64'd0);
    chk("t6_rst_err", 64'(timeout_err), 64'd0);
    req_rw_flag[0] = 3'd1; req_addr[0] = 32'h900;
    tick(1);
    rst = 1'b0;
    wait_grant(2'b01, 3, "t6_first_grant0");
    chk("t6_addr0", 64'(dc_addr), 64'h900);
    wait_done(2'b01, 12, "t6_done0");
    chk("t6_rdata0", 64'(req_rdata[0]), 64'h9999_0000);
    req_rw_flag[0] = 3'd0;
    wait_done(2'b10, 20, "t6_done1");
    req_rw_flag[1] = 3'd0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
